// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with an iterative shift-add multiplier.
//
// One operation is accepted at a time on the in_valid/in_ready channel.
// ADD, SUB, AND, XOR, COM, ADDI and the reserved opcode produce a result
// one cycle after accept.  MUL runs a shift-add loop for DSIZE cycles and
// returns the full double-width product on {out_hi, out}.  The result and
// flags are held on the out_valid/out_ready channel until consumed.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept an operation this cycle
//   a, b       operands (ADDI: signed immediate in b[IMMW-1:0])
//   op         opcode: ADD=0 SUB=1 AND=2 XOR=3 COM=4 MUL=5 ADDI=6, 7 reserved
//   out_valid  result available
//   out_ready  consumer takes the result
//   out        result low half
//   out_hi     MUL high half, 0 for other ops
//   carry      carry (ADD/ADDI) or borrow (SUB)
//   ovf        signed overflow (ADD/ADDI/SUB) or nonzero high half (MUL)
//   zero       out == 0
module alu_seq #(
  parameter int DSIZE = 8,
  parameter int IMMW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out,
  output logic [DSIZE-1:0] out_hi,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(DSIZE + 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_COM  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DSIZE-1:0]  mcand_p0;
  logic [DSIZE-1:0]  acc_hi_p0;
  logic [DSIZE-1:0]  acc_lo_p0;

  logic              accept;

  logic [DSIZE-1:0]  b_eff;
  logic [DSIZE:0]    sum_w;
  logic [DSIZE-1:0]  alu_res;
  logic              alu_c;
  logic              alu_v;

  logic [DSIZE:0]    mul_sum;
  logic [DSIZE-1:0]  step_hi;
  logic [DSIZE-1:0]  step_lo;

  // Sign-extend the ADDI immediate to the full operand width.
  function automatic logic [DSIZE-1:0] sext_imm(input logic [IMMW-1:0] x);
    logic signed [IMMW-1:0] s;
    s = $signed(x);
    return DSIZE'(s);
  endfunction

  // Signed overflow: the exact (DSIZE+1)-bit result differs from the
  // sign extension of its truncated DSIZE-bit value.
  function automatic logic add_ovf(input logic signed [DSIZE-1:0] x,
                                   input logic signed [DSIZE-1:0] y);
    logic signed [DSIZE:0]   w;
    logic signed [DSIZE-1:0] t;
    w = (DSIZE+1)'(x) + (DSIZE+1)'(y);
    t = w[DSIZE-1:0];
    return w != (DSIZE+1)'(t);
  endfunction

  function automatic logic sub_ovf(input logic signed [DSIZE-1:0] x,
                                   input logic signed [DSIZE-1:0] y);
    logic signed [DSIZE:0]   w;
    logic signed [DSIZE-1:0] t;
    w = (DSIZE+1)'(x) - (DSIZE+1)'(y);
    t = w[DSIZE-1:0];
    return w != (DSIZE+1)'(t);
  endfunction

  assign in_ready = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // Single-cycle datapath, evaluated on the live inputs and registered on accept.
  always_comb begin
    b_eff   = (op == OP_ADDI) ? sext_imm(b[IMMW-1:0]) : b;
    sum_w   = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        sum_w   = {1'b0, a} + {1'b0, b_eff};
        alu_res = sum_w[DSIZE-1:0];
        alu_c   = sum_w[DSIZE];
        alu_v   = add_ovf($signed(a), $signed(b_eff));
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        sum_w   = {1'b0, a} - {1'b0, b};
        alu_res = sum_w[DSIZE-1:0];
        alu_c   = sum_w[DSIZE];
        alu_v   = sub_ovf($signed(a), $signed(b));
      end
      OP_AND:  alu_res = a & b;
      OP_XOR:  alu_res = a ^ b;
      OP_COM:  alu_res[0] = (a <= b);
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper
  // half, then shift the whole {carry, hi, lo} accumulator right by one.
  // The multiplier occupies acc_lo and is consumed from its LSB.
  always_comb begin
    mul_sum = {1'b0, acc_hi_p0} + (acc_lo_p0[0] ? {1'b0, mcand_p0} : '0);
    step_hi = mul_sum[DSIZE:1];
    step_lo = {mul_sum[0], acc_lo_p0[DSIZE-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      mcand_p0  <= '0;
      acc_hi_p0 <= '0;
      acc_lo_p0 <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state     <= S_MUL;
              cnt       <= CW'(DSIZE);
              mcand_p0  <= a;
              acc_hi_p0 <= '0;
              acc_lo_p0 <= b;
              out_valid <= 1'b0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out       <= alu_res;
              out_hi    <= '0;
              carry     <= alu_c;
              ovf       <= alu_v;
              zero      <= (alu_res == '0);
            end
          end else if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        // ---- multiply iteration stage ----
        S_MUL: begin
          acc_hi_p0 <= step_hi;
          acc_lo_p0 <= step_lo;
          cnt       <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out       <= step_lo;
            out_hi    <= step_hi;
            carry     <= 1'b0;
            ovf       <= (step_hi != '0);
            zero      <= (step_lo == '0);
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (DSIZE=8, IMMW=4): scoreboard of expected results
// pushed on accept and popped when the result is consumed, plus directed
// timing, backpressure and reset checks.
module tb_alu_seq;

  localparam int DSIZE = 8;
  localparam int IMMW  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] a;
  logic [DSIZE-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] out;
  logic [DSIZE-1:0] out_hi;
  logic             carry;
  logic             ovf;
  logic             zero;

  alu_seq #(.DSIZE(DSIZE), .IMMW(IMMW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_hi    (out_hi),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit bp_mode = 1'b0;

  // Packed result: {out_hi, out, carry, ovf, zero}
  typedef struct {
    logic [18:0] res;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model using plain integer arithmetic.
  function automatic logic [18:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, r, s, imm;
    logic [7:0] lo, hi;
    logic c, v;
    ux = x; uy = y;
    sx = (x >= 128) ? ux - 256 : ux;
    sy = (y >= 128) ? uy - 256 : uy;
    lo = 0; hi = 0; c = 0; v = 0;
    case (o)
      3'd0: begin
        r = ux + uy; lo = r[7:0]; c = (r > 255);
        s = sx + sy; v = (s > 127) || (s < -128);
      end
      3'd1: begin
        r = ux - uy; lo = r[7:0]; c = (ux < uy);
        s = sx - sy; v = (s > 127) || (s < -128);
      end
      3'd2: lo = x & y;
      3'd3: lo = x ^ y;
      3'd4: lo = (ux <= uy) ? 8'd1 : 8'd0;
      3'd5: begin
        r = ux * uy; lo = r[7:0]; hi = r[15:8]; v = (hi != 0);
      end
      3'd6: begin
        imm = y[3:0];
        if (imm >= 8) imm = imm - 16;
        r = ux + (imm & 255); lo = r[7:0]; c = (r > 255);
        s = sx + imm; v = (s > 127) || (s < -128);
      end
      default: lo = 0;
    endcase
    return {hi, lo, c, v, (lo == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation; returns 1 ns after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit push);
    exp_t e;
    bit done;
    done = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i < 300 && !done; i++) begin
      if (bp_mode) out_ready = 1'($urandom_range(0, 1));
      #0;
      if (in_ready) begin
        if (push) begin
          e.res = model(o, x, y); e.op = o; e.a = x; e.b = y;
          sb_q.push_back(e);
        end
        done = 1'b1;
      end
      tick();
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  // Consumption monitor: a result seen valid+ready here is taken at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", {13'd0, out_hi, out, carry, ovf, zero}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("op%0d_%02h_%02h", e.op, e.a, e.b),
            {13'd0, out_hi, out, carry, ovf, zero}, {13'd0, e.res});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {out_hi, out, carry, ovf, zero}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // ADD latency and value
    send(3'd0, 8'hF0, 8'h20, 1);
    chk("add_lat_valid", out_valid, 1);
    chk("add_f0_20", {out, carry, ovf, zero}, {8'h10, 3'b100});

    // Directed vectors back to back
    send(3'd0, 8'h7F, 8'h01, 1);
    send(3'd1, 8'h05, 8'h07, 1);
    send(3'd1, 8'h80, 8'h01, 1);
    send(3'd4, 8'h03, 8'h03, 1);
    send(3'd3, 8'hAA, 8'hAA, 1);
    send(3'd6, 8'h10, 8'h0F, 1);
    chk("addi_imm_m1", {out, carry}, {8'h0F, 1'b1});
    send(3'd7, 8'h5A, 8'hC3, 1);
    chk("rsvd_op", {out_hi, out, carry, ovf, zero}, {16'h0, 3'b001});
    send(3'd5, 8'h0C, 8'h0A, 1);
    tick(); // drain any leftover so the FF*FF timing starts from a known point
    repeat (10) if (out_valid) tick();

    // MUL FF*FF: result exactly 8 cycles after accept, busy throughout
    send(3'd5, 8'hFF, 8'hFF, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_wait_valid_%0d", i), out_valid, 0);
      chk($sformatf("mul_wait_ready_%0d", i), in_ready, 0);
      tick();
    end
    chk("mul_lat_valid", out_valid, 1);
    chk("mul_ff_ff", {out_hi, out, carry, ovf}, {8'hFE, 8'h01, 2'b01});
    tick();

    // Backpressure: ADD result held for 5 cycles
    out_ready = 1'b0;
    send(3'd0, 8'h7F, 8'h01, 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_%0d", i), {out_valid, in_ready, out, carry, ovf, zero},
          {1'b1, 1'b0, 8'h80, 3'b010});
      tick();
    end
    out_ready = 1'b1;
    send(3'd2, 8'h0F, 8'h3C, 1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_and", out, 8'h0C);
    tick();

    // Reset in cycle 3 of a MUL
    send(3'd5, 8'hFF, 8'hFF, 0);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("midmul_rst_valid", out_valid, 0);
    chk("midmul_rst_outs", {out_hi, out, carry, ovf, zero}, 0);
    chk("midmul_rst_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("midmul_rel_ready", in_ready, 1);
    send(3'd0, 8'h01, 8'h01, 1);
    chk("post_rst_add", {out_valid, out}, {1'b1, 8'h02});
    tick();

    // Random operations with random output backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1);
    end
    bp_mode = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    chk("drain_queue", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's 3-bit-opcode combinational ALU.
- Accepts one operation at a time on a valid/ready input channel.
- Single-cycle ops complete in 1 cycle; MUL uses an iterative shift-add engine over DSIZE cycles and returns a full double-width product.
- Holds the registered result and flags on a valid/ready output channel until consumed; sits between the register-file read ports and the writeback path.

Parameters:
- DSIZE, 8, operand/result width (>=2).
- IMMW, 4, ADDI immediate width (1..DSIZE); b[IMMW-1:0] is sign-extended to DSIZE.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- a  in  DSIZE  1st operand.
- b  in  DSIZE  2nd operand (ADDI: immediate in low IMMW bits).
- op  in  3  opcode.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out  out  DSIZE  result low half.
- out_hi  out  DSIZE  MUL high half; 0 for other ops.
- carry  out  1  carry/borrow flag.
- ovf  out  1  signed-overflow / MUL-overflow flag.
- zero  out  1  out==0.

Behaviour:
- Opcodes (values fixed, matching define.v macros): ADD=0, SUB=1, AND=2, XOR=3, COM=4, MUL=5, ADDI=6, 7=reserved.
- Reserved opcode: out=0, out_hi=0, flags 0 except zero=1; completes in 1 cycle.
- States: IDLE, MUL, DONE.
- in_ready = rst_n & ((state==IDLE) | (state==DONE & out_ready)).
- Accept: in_valid & in_ready at rising edge; a, b, op captured.
- Non-MUL accepted: results registered; state=DONE next cycle, so out_valid=1 exactly 1 cycle after accept.
- MUL accepted: state=MUL, cnt=DSIZE, accumulator cleared.
  - Each MUL cycle: if multiplier LSB set, add multiplicand into upper accumulator; shift right 1; cnt--.
  - After DSIZE MUL cycles, state=DONE; out_valid rises exactly DSIZE cycles after accept.
- DONE: outputs stable while out_valid & !out_ready.
  - out_ready=1 without new accept: -> IDLE, out_valid=0.
  - out_ready=1 with new accept (back-to-back): old result consumed, new op starts the same edge. Non-MUL: out_valid stays 1 with new data next cycle. MUL: -> MUL state.
- Arithmetic (unsigned for carry, two's complement for ovf):
  - ADD/ADDI: {carry,out}=a+b' (b'=b, or sign-extended imm for ADDI); ovf = sign(a)==sign(b') & sign(out)!=sign(a).
  - SUB: out=a-b mod 2^DSIZE; carry=1 iff a<b unsigned (borrow); ovf = sign(a)!=sign(b) & sign(out)!=sign(a).
  - AND, XOR: bitwise; carry=ovf=0.
  - COM: out = zero-extended (a<=b unsigned); carry=ovf=0.
  - MUL: unsigned {out_hi,out}=a*b; ovf = (out_hi!=0); carry=0.
  - zero = (out==0) for all ops; out_hi=0 for non-MUL.
- Inputs a/b/op may change freely while busy; only captured values are used.
- Reset (rst_n=0 at an edge, any state incl. mid-MUL): state=IDLE, cnt=0, out=out_hi=0, carry=ovf=zero=0, out_valid=0; in_ready=0 while rst_n=0, 1 on first cycle after release.
- No output is driven X after reset; no combinational path from in_valid to out_valid.

Test Plan:
- DSIZE=8: ADD a=0xF0 b=0x20 -> 1 cycle later out=0x10, carry=1, ovf=0, zero=0; ADD 0x7F+0x01 -> out=0x80, ovf=1, carry=0.
- SUB a=0x05 b=0x07 -> out=0xFE, carry=1, ovf=0; SUB 0x80-0x01 -> out=0x7F, ovf=1; COM 3<=3 -> out=0x01; XOR 0xAA^0xAA -> out=0, zero=1.
- ADDI, IMMW=4: a=0x10, b=0x0F -> imm=-1, out=0x0F, carry=1; op=7 -> out=0, zero=1.
- MUL 0xFF*0xFF -> out_valid exactly 8 cycles after accept, out_hi=0xFE, out=0x01, ovf=1; in_ready=0 throughout; MUL 0x0C*0x0A -> out=0x78, out_hi=0, ovf=0.
- Backpressure: hold out_ready=0 5 cycles after ADD -> outputs stable, in_ready=0. Raise out_ready with in_valid=1 (AND 0x0F&0x3C) -> accepted same edge, next cycle out=0x0C, out_valid stays 1.
- Reset mid-MUL (cycle 3 of 8) -> next edge: out_valid=0, all outputs 0, state IDLE. A new ADD 1+1 after release -> out=0x02 one cycle after accept.
